// File: rtl/matbi_watch_pkg.sv
// Shared encodings and default limits for the watch controller.
// The FSM states and field selectors are kept as plain 2-bit constants.
package matbi_watch_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_SET   = 2'd3;

    localparam logic [1:0] FLD_SEC  = 2'd0;
    localparam logic [1:0] FLD_MIN  = 2'd1;
    localparam logic [1:0] FLD_HOUR = 2'd2;

    localparam int DEF_SEC_MAX  = 59;
    localparam int DEF_HOUR_MAX = 23;
    localparam int SEC_W        = 6;
    localparam int HOUR_W       = 5;

    // Set-mode field selection cycles sec -> min -> hour -> sec.
    function automatic logic [1:0] next_field(input logic [1:0] f);
        return (f == FLD_HOUR) ? FLD_SEC : f + 2'd1;
    endfunction
endpackage

// File: rtl/matbi_wrap_cnt.sv
// Wrapping counter for a single time field. wrap flags a step request
// that lands on MAX, so the caller can build the carry chain from it.
module matbi_wrap_cnt #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         carry_in_en,
    output logic [W-1:0] value,
    output logic         wrap
);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] value_q, value_d;

    assign wrap  = inc && (value_q == MAX_V);
    assign value = value_q;

    always_comb begin
        value_d = value_q;
        if (inc && carry_in_en)
            value_d = (value_q == MAX_V) ? '0 : value_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) value_q <= '0;
        else       value_q <= value_d;
    end
endmodule

// File: rtl/matbi_watch_ctrl.sv
// Watch controller: run/pause/set FSM driving three wrapping time fields.
// State change and time update are both decided from the pre-edge state.
module matbi_watch_ctrl #(
    parameter int P_SEC_MAX  = matbi_watch_pkg::DEF_SEC_MAX,
    parameter int P_HOUR_MAX = matbi_watch_pkg::DEF_HOUR_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_set,
    input  logic       i_btn_inc,
    input  logic       i_one_sec_tick,
    input  logic       i_btn_tick,
    output logic       o_run_en,
    output logic [1:0] o_state,
    output logic [1:0] o_field,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour
);
    import matbi_watch_pkg::*;

    logic [1:0] state_q, state_d;
    logic [1:0] field_q, field_d;
    logic       run_en_q;
    logic       btn_q;
    logic       run_tick, set_inc, cnt_en;
    logic       sec_inc, min_inc, hour_inc;
    logic       sec_wrap, min_wrap, hour_wrap;

    always_comb begin
        state_d = state_q;
        field_d = field_q;
        case (state_q)
            ST_IDLE:
                if (i_start) state_d = ST_RUN;
            ST_RUN:
                if (i_stop) state_d = ST_PAUSE;
                else if (i_set) begin
                    state_d = ST_SET;
                    field_d = FLD_SEC;
                end
            ST_PAUSE:
                if (i_set) begin
                    state_d = ST_SET;
                    field_d = FLD_SEC;
                end else if (i_start) state_d = ST_RUN;
            default:
                if (i_set) field_d = next_field(field_q);
                else if (i_start) state_d = ST_RUN;
        endcase
    end

    // Rising edge, or an auto-repeat tick while still held: never both counted.
    assign set_inc  = (state_q == ST_SET) && i_btn_inc && (!btn_q || i_btn_tick);
    assign run_tick = (state_q == ST_RUN) && i_one_sec_tick;
    assign cnt_en   = (state_q == ST_RUN) || (state_q == ST_SET);

    assign sec_inc  = run_tick || (set_inc && field_q == FLD_SEC);
    assign min_inc  = (run_tick && sec_wrap) || (set_inc && field_q == FLD_MIN);
    assign hour_inc = (run_tick && sec_wrap && min_wrap) || (set_inc && field_q == FLD_HOUR);

    matbi_wrap_cnt #(.W(SEC_W), .MAX(P_SEC_MAX)) u_sec (
        .clk(clk), .reset(reset), .inc(sec_inc), .carry_in_en(cnt_en),
        .value(o_sec), .wrap(sec_wrap)
    );
    matbi_wrap_cnt #(.W(SEC_W), .MAX(P_SEC_MAX)) u_min (
        .clk(clk), .reset(reset), .inc(min_inc), .carry_in_en(cnt_en),
        .value(o_min), .wrap(min_wrap)
    );
    matbi_wrap_cnt #(.W(HOUR_W), .MAX(P_HOUR_MAX)) u_hour (
        .clk(clk), .reset(reset), .inc(hour_inc), .carry_in_en(cnt_en),
        .value(o_hour), .wrap(hour_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            field_q  <= FLD_SEC;
            run_en_q <= 1'b0;
            btn_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            field_q  <= field_d;
            run_en_q <= (state_d == ST_RUN) || (state_d == ST_SET);
            btn_q    <= i_btn_inc;
        end
    end

    assign o_state  = state_q;
    assign o_field  = field_q;
    assign o_run_en = run_en_q;

    // Top-level carry out of the hour field has no consumer.
    logic unused_hour_wrap;
    assign unused_hour_wrap = hour_wrap;
endmodule

// File: tb/tb_matbi_watch_ctrl.sv
// Self-checking bench: time kept as a seconds-of-day count in a behavioural
// model, directed scenarios with literal pins, then randomized traffic.
module tb_matbi_watch_ctrl;
    localparam int SN = 60;
    localparam int HN = 24;

    logic       clk = 1'b0;
    logic       reset, i_start, i_stop, i_set, i_btn_inc, i_one_sec_tick, i_btn_tick;
    logic       o_run_en;
    logic [1:0] o_state, o_field;
    logic [5:0] o_sec, o_min;
    logic [4:0] o_hour;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int st;
        int fld;
        int s;
        int m;
        int h;
        bit btn;
    } mdl_t;

    mdl_t mdl = '{st: 0, fld: 0, s: 0, m: 0, h: 0, btn: 1'b0};

    matbi_watch_ctrl dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_stop(i_stop), .i_set(i_set),
        .i_btn_inc(i_btn_inc), .i_one_sec_tick(i_one_sec_tick), .i_btn_tick(i_btn_tick),
        .o_run_en(o_run_en), .o_state(o_state), .o_field(o_field),
        .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour)
    );

    always #5 clk = ~clk;

    function automatic mdl_t step(input mdl_t c, input bit rs, st, sp, se, bi, tk, bt);
        mdl_t n = c;
        if (rs) return '{st: 0, fld: 0, s: 0, m: 0, h: 0, btn: 1'b0};
        if (c.st == 1 && tk) begin
            int t = ((c.h * SN + c.m) * SN + c.s + 1) % (HN * SN * SN);
            n.s = t % SN;
            n.m = (t / SN) % SN;
            n.h = t / (SN * SN);
        end
        if (c.st == 3 && bi && (!c.btn || bt)) begin
            if (c.fld == 0)      n.s = (c.s + 1) % SN;
            else if (c.fld == 1) n.m = (c.m + 1) % SN;
            else                 n.h = (c.h + 1) % HN;
        end
        case (c.st)
            0: if (st) n.st = 1;
            1: if (sp) n.st = 2; else if (se) begin n.st = 3; n.fld = 0; end
            2: if (se) begin n.st = 3; n.fld = 0; end else if (st) n.st = 1;
            default: if (se) n.fld = (c.fld + 1) % 3; else if (st) n.st = 1;
        endcase
        n.btn = bi;
        return n;
    endfunction

    always @(posedge clk)
        mdl <= step(mdl, reset, i_start, i_stop, i_set, i_btn_inc, i_one_sec_tick, i_btn_tick);

    task automatic compare();
        int exp_en;
        exp_en = (mdl.st == 1 || mdl.st == 3) ? 1 : 0;
        n_chk++;
        if (int'(o_state) != mdl.st || int'(o_run_en) != exp_en || int'(o_field) != mdl.fld ||
            int'(o_sec) != mdl.s || int'(o_min) != mdl.m || int'(o_hour) != mdl.h) begin
            n_fail++;
            $display("FAIL cycle @%0t: got st=%0d en=%0d fld=%0d %0d:%0d:%0d, exp st=%0d en=%0d fld=%0d %0d:%0d:%0d",
                     $time, o_state, o_run_en, o_field, o_hour, o_min, o_sec,
                     mdl.st, exp_en, mdl.fld, mdl.h, mdl.m, mdl.s);
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then check outputs at the following negedge.
    task automatic cyc(input bit rs, st, sp, se, bi, tk, bt);
        reset = rs; i_start = st; i_stop = sp; i_set = se;
        i_btn_inc = bi; i_one_sec_tick = tk; i_btn_tick = bt;
        @(negedge clk);
        compare();
    endtask

    task automatic press(input int n);
        repeat (n) begin
            cyc(0, 0, 0, 0, 1, 0, 0);
            cyc(0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        bit btn;
        cyc(1, 0, 0, 0, 0, 0, 0);
        lit("reset_state", int'(o_state), 0);
        lit("reset_time", int'(o_sec) + int'(o_min) + int'(o_hour) + int'(o_run_en), 0);

        // Start, three seconds.
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        lit("first_tick_sec", int'(o_sec), 1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        lit("run_sec3", int'(o_sec), 3);
        lit("run_state", int'(o_state), 1);
        lit("run_en", int'(o_run_en), 1);
        lit("model_sec3", mdl.s, 3);

        // Preload 23:59:59 and roll over in one tick.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        press(59);
        cyc(0, 0, 0, 1, 0, 0, 0);
        press(59);
        cyc(0, 0, 0, 1, 0, 0, 0);
        press(23);
        lit("preload_hms", int'(o_hour) * 10000 + int'(o_min) * 100 + int'(o_sec), 235959);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        lit("rollover_hms", int'(o_hour) * 10000 + int'(o_min) * 100 + int'(o_sec), 0);
        lit("model_rollover", mdl.h + mdl.m + mdl.s, 0);

        // Stop and tick in the same RUN cycle.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 1, 0);
        lit("stop_tick_sec", int'(o_sec), 11);
        lit("stop_state", int'(o_state), 2);
        lit("stop_run_en", int'(o_run_en), 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 1, 0);
        lit("pause_sec_hold", int'(o_sec), 11);

        // Minute field auto-repeat across the wrap, no carry into hour.
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        lit("field_min", int'(o_field), 1);
        press(58);
        lit("min58", int'(o_min), 58);
        cyc(0, 0, 0, 0, 1, 0, 0);
        lit("min_edge", int'(o_min), 59);
        cyc(0, 0, 0, 0, 1, 0, 1);
        lit("min_rep_wrap", int'(o_min), 0);
        cyc(0, 0, 0, 0, 1, 0, 1);
        lit("min_rep2", int'(o_min), 1);
        lit("hour_nocarry", int'(o_hour), 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // All three pulses in SET: field advances, state held.
        cyc(0, 1, 1, 1, 0, 0, 0);
        lit("combo_field", int'(o_field), 2);
        lit("combo_state", int'(o_state), 3);

        // Reset mid-SET.
        press(5);
        lit("hour5", int'(o_hour), 5);
        cyc(1, 0, 0, 0, 1, 1, 1);
        lit("rst_mid_set", int'(o_state) + int'(o_field) + int'(o_run_en) +
            int'(o_sec) + int'(o_min) + int'(o_hour), 0);

        // Randomized traffic.
        btn = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(3) == 0) btn = ~btn;
            cyc($urandom_range(299) == 0, $urandom_range(15) == 0, $urandom_range(15) == 0,
                $urandom_range(11) == 0, btn, $urandom_range(2) == 0, $urandom_range(3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
